axis_packet_rr_arbiter: RTL and testbench
=========================================

Name: axis_packet_rr_arbiter

Overview:
Packet-granular round-robin arbiter that shares one egress AXI-Stream network interface among NUM_PORTS tenant streams. It sits in front of the packet-mode FIFO / loopback datapath and the TX network port. A grant is held for a whole packet, so packets are never interleaved. The granted port index is stamped on tid so downstream logic and counters can attribute each packet to its source.

Parameters:
NUM_PORTS, 4, number of requesting input streams (2..16).
AXIS_BUS_WIDTH, 64, tdata width in bits; must be a multiple of 8.
AXIS_ID_WIDTH, 4, output tid width; must be >= clog2(NUM_PORTS).
AXIS_DEST_WIDTH, 4, tdest width.

Ports:
aclk  in  1  clock; all logic is synchronous to its rising edge.
aresetn  in  1  reset, asynchronous and active-low; all state clears immediately on assertion.
axis_in_tdata  in  NUM_PORTS*AXIS_BUS_WIDTH  flattened tdata; port i occupies slice i.
axis_in_tkeep  in  NUM_PORTS*AXIS_BUS_WIDTH/8  flattened tkeep.
axis_in_tdest  in  NUM_PORTS*AXIS_DEST_WIDTH  flattened tdest.
axis_in_tlast  in  NUM_PORTS  per-port tlast.
axis_in_tvalid  in  NUM_PORTS  per-port tvalid.
axis_in_tready  out  NUM_PORTS  per-port tready.
axis_out_tdata  out  AXIS_BUS_WIDTH  egress tdata.
axis_out_tkeep  out  AXIS_BUS_WIDTH/8  egress tkeep.
axis_out_tid  out  AXIS_ID_WIDTH  granted port index, zero-extended.
axis_out_tdest  out  AXIS_DEST_WIDTH  tdest of the granted port.
axis_out_tlast  out  1  egress tlast.
axis_out_tvalid  out  1  egress tvalid.
axis_out_tready  in  1  egress tready.
port_enable  in  NUM_PORTS  per-port arbitration enable; sampled only in IDLE.
cur_grant  out  clog2(NUM_PORTS)  registered index of the current or last grant.
busy  out  1  high while in PASS.

Behaviour:
- FSM states are IDLE and PASS. Reset forces IDLE, cur_grant=0, last_grant=NUM_PORTS-1, busy=0, all axis_in_tready=0, axis_out_tvalid=0.
- IDLE: req = axis_in_tvalid & port_enable.
  - If req is nonzero, choose the first set bit searching upward from last_grant+1 with modulo wrap.
  - Register the result in cur_grant and go to PASS.
  - No tready is asserted in IDLE, so there is one bubble cycle per packet.
  - If req is zero, stay in IDLE.
- PASS: the egress is a combinational pass-through of port cur_grant.
  - axis_out_tvalid = axis_in_tvalid[cur_grant].
  - axis_in_tready[cur_grant] = axis_out_tready; all other tready are 0.
  - tdata, tkeep, tdest and tlast come from slice cur_grant. tid = cur_grant.
  - busy=1.
- Leaving PASS: when axis_out_tvalid & axis_out_tready & axis_out_tlast, set last_grant<=cur_grant and go to IDLE on the next cycle.
- Beat latency is 0 cycles in PASS. Packet-start latency is 1 cycle after the request is seen in IDLE.
- A single-beat packet (tlast on the first beat) occupies 1 PASS cycle if tready is high, then returns to IDLE.
- If the granted port drops tvalid mid-packet, hold in PASS indefinitely with out tvalid=0. No timeout and no preemption.
- Deasserting port_enable[cur_grant] mid-packet has no effect until tlast. The port is then excluded from later arbitration.
- A port with tvalid high but enable low is never granted and its tready stays 0.
- Outputs are not registered, so egress AXI-S stability follows from input stability.
- Wrap-around: if last_grant=NUM_PORTS-1, the search starts at port 0.
- Asynchronous reset mid-packet:
  - Outputs drop immediately (tvalid=0, tready=0).
  - The partial packet is truncated; downstream must tolerate this, since the packet-mode FIFO drops incomplete packets.
  - After reset release, arbitration restarts from port 0.

Test Plan:
- Single requester: port 2 sends a 3-beat packet with out tready=1 -> tvalid high 1 cycle after request, 3 beats with tid=2 and tdata matching, busy drops after tlast, cur_grant=2.
- All 4 ports continuously valid with 2-beat packets -> grant order 0,1,2,3,0,1; no beat interleaving; exactly 1 bubble cycle between packets.
- Backpressure: out tready toggles 1,0,1,0 during a 4-beat packet from port 1 -> no beat lost or duplicated, other ports' tready stays 0, tdata held stable while tready=0.
- port_enable=4'b1011 with all ports valid -> port 2 is never granted and its tready stays 0; order is 0,1,3,0. Clearing enable[1] mid-packet from port 1 completes that packet.
- Wrap and single-beat case: last_grant=3, only port 0 valid with tlast on the first beat -> grant 0, 1 PASS cycle, return to IDLE.
- aresetn pulsed low mid-packet at beat 2 of 5 -> tvalid and tready go 0 asynchronously, busy=0; after release the next grant is port 0.

Source files
------------

// File: rtl/axis_packet_rr_arbiter_if.sv
// Bundles the tenant ingress streams and the shared egress stream of the packet arbiter.
// Latency: n/a (wires only).
// Backpressure: carries per-port tready back to tenants and egress tready into the arbiter.
//
// Signals:
//   axis_in_*   flattened per-port ingress streams (port i occupies slice i)
//   axis_out_*  single egress stream, tid carries the source port index
// Modports:
//   slave   the arbiter's view: consumes the ingress streams and produces the egress stream
//   master  the environment's view: tenant sources plus the egress sink
interface axis_packet_rr_arbiter_if #(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4
);
  localparam int KEEP_WIDTH = AXIS_BUS_WIDTH / 8;

  logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]  axis_in_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0]      axis_in_tkeep;
  logic [NUM_PORTS*AXIS_DEST_WIDTH-1:0] axis_in_tdest;
  logic [NUM_PORTS-1:0]                 axis_in_tlast;
  logic [NUM_PORTS-1:0]                 axis_in_tvalid;
  logic [NUM_PORTS-1:0]                 axis_in_tready;

  logic [AXIS_BUS_WIDTH-1:0]            axis_out_tdata;
  logic [KEEP_WIDTH-1:0]                axis_out_tkeep;
  logic [AXIS_ID_WIDTH-1:0]             axis_out_tid;
  logic [AXIS_DEST_WIDTH-1:0]           axis_out_tdest;
  logic                                 axis_out_tlast;
  logic                                 axis_out_tvalid;
  logic                                 axis_out_tready;

  modport slave (
    input  axis_in_tdata, axis_in_tkeep, axis_in_tdest, axis_in_tlast, axis_in_tvalid,
    output axis_in_tready,
    output axis_out_tdata, axis_out_tkeep, axis_out_tid, axis_out_tdest,
    output axis_out_tlast, axis_out_tvalid,
    input  axis_out_tready
  );

  modport master (
    output axis_in_tdata, axis_in_tkeep, axis_in_tdest, axis_in_tlast, axis_in_tvalid,
    input  axis_in_tready,
    input  axis_out_tdata, axis_out_tkeep, axis_out_tid, axis_out_tdest,
    input  axis_out_tlast, axis_out_tvalid,
    output axis_out_tready
  );
endinterface

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one egress AXI-Stream among NUM_PORTS tenants.
// Latency: 1 idle (arbitration) cycle before each packet, then 0-cycle combinational beat pass-through.
// Backpressure: egress tready is routed only to the granted port; all other ports see tready=0.
//
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   axis           slave modport of axis_packet_rr_arbiter_if (ingress streams + egress stream)
//   port_enable    per-port arbitration enable, only consulted while choosing a new grant
//   cur_grant      registered index of the current (or most recent) grant
//   busy           high while a packet is being passed through
module axis_packet_rr_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axis_packet_rr_arbiter_if.slave      axis,
  input  logic [NUM_PORTS-1:0]         port_enable,
  output logic [$clog2(NUM_PORTS)-1:0] cur_grant,
  output logic                         busy
);
  localparam int GW         = $clog2(NUM_PORTS);
  localparam int GW1        = GW + 1;
  localparam int KEEP_WIDTH = AXIS_BUS_WIDTH / 8;
  // Port count at the width of the wrap-around adder, so the modulo compare/subtract stays same-width.
  localparam logic [GW:0] NUM_PORTS_W = GW1'(NUM_PORTS);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   cur_grant_q, cur_grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;

  logic [NUM_PORTS-1:0] req;
  logic [GW-1:0]        pick;
  logic                 pick_vld;
  logic [GW:0]          search_sum;
  logic [GW-1:0]        search_idx;
  logic                 pkt_end;

  // Round-robin search: walk offsets NUM_PORTS down to 1 from last_grant so the
  // smallest offset that hits a request is the one left standing. Offset NUM_PORTS
  // revisits last_grant itself, which lets a lone requester win back-to-back.
  always_comb begin
    req        = axis.axis_in_tvalid & port_enable;
    pick       = '0;
    pick_vld   = 1'b0;
    search_sum = '0;
    search_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      search_sum = {1'b0, last_grant_q} + GW1'(k);
      if (search_sum >= NUM_PORTS_W) begin
        search_sum = search_sum - NUM_PORTS_W;
      end
      search_idx = search_sum[GW-1:0];
      if (req[search_idx]) begin
        pick     = search_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // The final beat of the granted packet is accepted this cycle.
  assign pkt_end = (state_q == PASS)
                 && axis.axis_in_tvalid[cur_grant_q]
                 && axis.axis_in_tlast[cur_grant_q]
                 && axis.axis_out_tready;

  // State register. last_grant resets to the top port so the first search after
  // reset starts at port 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      cur_grant_q  <= '0;
      last_grant_q <= LAST_PORT;
    end else begin
      state_q      <= state_d;
      cur_grant_q  <= cur_grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic. The grant is held until tlast is accepted; port_enable is
  // only looked at while choosing, so disabling a port mid-packet lets it finish.
  always_comb begin
    state_d      = state_q;
    cur_grant_d  = cur_grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = PASS;
          cur_grant_d = pick;
        end
      end
      PASS: begin
        if (pkt_end) begin
          state_d      = IDLE;
          last_grant_d = cur_grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. Payload fields always follow the cur_grant slice; only the
  // handshake signals are gated by state, so reset kills tvalid/tready at once.
  always_comb begin
    axis.axis_in_tready  = '0;
    axis.axis_out_tvalid = 1'b0;
    axis.axis_out_tdata  = axis.axis_in_tdata[int'(cur_grant_q)*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
    axis.axis_out_tkeep  = axis.axis_in_tkeep[int'(cur_grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
    axis.axis_out_tdest  = axis.axis_in_tdest[int'(cur_grant_q)*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
    axis.axis_out_tlast  = axis.axis_in_tlast[cur_grant_q];
    axis.axis_out_tid    = AXIS_ID_WIDTH'(cur_grant_q);
    busy                 = 1'b0;
    if (state_q == PASS) begin
      axis.axis_out_tvalid             = axis.axis_in_tvalid[cur_grant_q];
      axis.axis_in_tready[cur_grant_q] = axis.axis_out_tready;
      busy                             = 1'b1;
    end
  end

  assign cur_grant = cur_grant_q;

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Randomized bench for the packet round-robin arbiter against a cycle-level reference model.
// Latency: model expects 1 arbitration cycle per packet and 0-cycle beat pass-through.
// Backpressure: egress tready is randomized; tenant sources hold each beat until accepted.
module tb_axis_packet_rr_arbiter;
  localparam int NP     = 4;
  localparam int BW     = 64;
  localparam int KW     = BW / 8;
  localparam int IW     = 4;
  localparam int DW     = 4;
  localparam int GW     = $clog2(NP);
  localparam int CYCLES = 4000;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [NP-1:0] port_enable;
  logic [GW-1:0] cur_grant;
  logic          busy;

  always #5 aclk = ~aclk;

  axis_packet_rr_arbiter_if #(
    .NUM_PORTS(NP), .AXIS_BUS_WIDTH(BW), .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW)
  ) axis_if ();

  axis_packet_rr_arbiter #(
    .NUM_PORTS(NP), .AXIS_BUS_WIDTH(BW), .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .axis        (axis_if),
    .port_enable (port_enable),
    .cur_grant   (cur_grant),
    .busy        (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Tenant source state: the beat currently presented by each port.
  logic [BW-1:0] src_dat  [NP];
  logic [KW-1:0] src_keep [NP];
  logic [DW-1:0] src_dest [NP];
  logic          src_last [NP];
  logic          src_vld  [NP];
  int            src_len  [NP];
  int            src_beat [NP];
  int            src_seq  [NP];
  int            pkts_done[NP];

  // Reference model: is a packet in flight, from which port, and who was served last.
  bit m_busy;
  int m_grant;
  int m_last;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_grant = 0;
    m_last  = NP - 1;
  endtask

  // Beat payload encodes port, packet sequence and beat index so any loss,
  // duplication or cross-port leak shows up as a tdata miscompare.
  task automatic load_beat(input int p);
    src_dat[p]  = {$urandom(), 8'(p), 8'(src_seq[p]), 16'(src_beat[p])};
    src_keep[p] = KW'($urandom());
    src_dest[p] = DW'($urandom());
    src_last[p] = (src_beat[p] == src_len[p] - 1);
    src_vld[p]  = 1'b1;
  endtask

  task automatic new_packet(input int p);
    src_beat[p] = 0;
    src_seq[p]  = src_seq[p] + 1;
    src_len[p]  = $urandom_range(1, 5);
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      axis_if.axis_in_tdata[p*BW +: BW] = src_dat[p];
      axis_if.axis_in_tkeep[p*KW +: KW] = src_keep[p];
      axis_if.axis_in_tdest[p*DW +: DW] = src_dest[p];
      axis_if.axis_in_tlast[p]          = src_last[p];
      axis_if.axis_in_tvalid[p]         = src_vld[p];
    end
  endtask

  initial begin
    logic [NP-1:0] exp_rdy;
    logic [NP-1:0] hs_in;
    bit            exp_vld;
    bit            n_busy;
    int            n_grant;
    int            n_last;
    int            sp;
    int            next_rst;

    aresetn                 = 1'b0;
    port_enable             = '1;
    axis_if.axis_out_tready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_dat[p]   = '0;
      src_keep[p]  = '0;
      src_dest[p]  = '0;
      src_last[p]  = 1'b0;
      src_vld[p]   = 1'b0;
      src_seq[p]   = 0;
      src_beat[p]  = 0;
      src_len[p]   = $urandom_range(1, 5);
      pkts_done[p] = 0;
    end
    drive_inputs();
    model_reset();
    next_rst = 200;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_cur_grant", cur_grant, 0);
    chk("rst_out_tvalid", axis_if.axis_out_tvalid, 0);
    chk("rst_in_tready", axis_if.axis_in_tready, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      // Fresh stimulus just after the active edge.
      for (int p = 0; p < NP; p++) begin
        if (!src_vld[p] && $urandom_range(0, 3) != 0) load_beat(p);
      end
      axis_if.axis_out_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        port_enable = ($urandom_range(0, 1) != 0) ? '1 : NP'($urandom());
      end
      drive_inputs();

      @(negedge aclk);
      exp_vld = m_busy && src_vld[m_grant];
      exp_rdy = '0;
      if (m_busy && axis_if.axis_out_tready) exp_rdy[m_grant] = 1'b1;
      chk("busy", busy, m_busy);
      chk("cur_grant", cur_grant, m_grant);
      chk("out_tvalid", axis_if.axis_out_tvalid, exp_vld);
      chk("in_tready", axis_if.axis_in_tready, exp_rdy);
      if (m_busy) chk("out_tid", axis_if.axis_out_tid, m_grant);
      if (exp_vld) begin
        chk("out_tdata", axis_if.axis_out_tdata, src_dat[m_grant]);
        chk("out_tkeep", axis_if.axis_out_tkeep, src_keep[m_grant]);
        chk("out_tdest", axis_if.axis_out_tdest, src_dest[m_grant]);
        chk("out_tlast", axis_if.axis_out_tlast, src_last[m_grant]);
      end

      // Model step: hold the grant until tlast is accepted; when idle, pick the
      // first enabled requester after the last served port, wrapping modulo NP.
      n_busy  = m_busy;
      n_grant = m_grant;
      n_last  = m_last;
      if (m_busy) begin
        if (exp_vld && axis_if.axis_out_tready && src_last[m_grant]) begin
          n_busy = 1'b0;
          n_last = m_grant;
        end
      end else begin
        for (int k = 1; k <= NP; k++) begin
          sp = (m_last + k) % NP;
          if (src_vld[sp] && port_enable[sp]) begin
            n_busy  = 1'b1;
            n_grant = sp;
            break;
          end
        end
      end
      for (int p = 0; p < NP; p++) hs_in[p] = src_vld[p] && axis_if.axis_in_tready[p];

      if (m_busy && cyc >= next_rst) begin
        // Asynchronous reset in the middle of a packet: handshakes must collapse
        // immediately, and the truncated packet is abandoned by its source.
        next_rst = cyc + 300;
        #2 aresetn = 1'b0;
        #1;
        chk("arst_out_tvalid", axis_if.axis_out_tvalid, 0);
        chk("arst_in_tready", axis_if.axis_in_tready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cur_grant", cur_grant, 0);
        src_vld[m_grant] = 1'b0;
        new_packet(m_grant);
        model_reset();
        @(posedge aclk);
        #1 aresetn = 1'b1;
      end else begin
        @(posedge aclk);
        #1;
        m_busy  = n_busy;
        m_grant = n_grant;
        m_last  = n_last;
        for (int p = 0; p < NP; p++) begin
          if (hs_in[p]) begin
            src_vld[p] = 1'b0;
            if (src_last[p]) begin
              pkts_done[p] = pkts_done[p] + 1;
              new_packet(p);
            end else begin
              src_beat[p] = src_beat[p] + 1;
            end
          end
        end
      end
    end

    for (int p = 0; p < NP; p++) begin
      chk("port_progress", (pkts_done[p] > 0), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
